// File: rtl/stream_buffer.sv
// FIFO buffer for valid/ready streams with registered fill level.
// ready_o depends only on local state and flush_i, so no ready path crosses the block.
module stream_buffer #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned payload_w   = 1,
    parameter bit          FallThrough = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [payload_w-1:0]       payload_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [payload_w-1:0]       payload_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth < 1) begin : g_depth_check
        $error("stream_buffer: Depth must be at least 1");
    end

    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [payload_w-1:0] mem_q [Depth];

    logic empty, full, push, pop, bypass, mem_we;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));

    assign ready_o = !full && !flush_i;
    assign valid_o = (FallThrough ? (!empty || valid_i) : !empty) && !flush_i;
    assign payload_o = (FallThrough && empty) ? payload_i : mem_q[rd_ptr_q];
    assign usage_o   = count_q;

    assign push   = valid_i && ready_o;
    assign pop    = valid_o && ready_i;
    // Empty fall-through transfer goes straight through without touching storage.
    assign bypass = FallThrough && empty && push && pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!bypass) begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no reset; count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= payload_i;
        end
    end

endmodule
